// File: rtl/cpu_sram_resp.sv
// cpu_sram_resp: SRAM responder for the core's inst and data ports.
// One shared word array, true dual-port, 1-cycle read latency, byte-enable
// writes on the data port only. The data port also decodes an MMIO window
// (addr[31:16] == MMIO_HI) holding an LED register and a free-running timer.
// Optional macro SRAM_PERF_CNT_EN adds three read-only access counters.
module cpu_sram_resp #(
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [15:0] MMIO_HI    = 16'hbfaf
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [13:0] OFS_LED   = 14'h0000;
  localparam logic [13:0] OFS_TIMER = 14'h0001;
`ifdef SRAM_PERF_CNT_EN
  localparam logic [13:0] OFS_IRD   = 14'h0004;
  localparam logic [13:0] OFS_DRD   = 14'h0005;
  localparam logic [13:0] OFS_DWR   = 14'h0006;
`endif

  // Replace the byte lanes selected by be with the matching lanes of nw.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] nw,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] iidx;
  logic [DEPTH_LOG2-1:0] didx;
  logic [13:0]           ofs;
  logic                  mmio_sel;
  logic                  d_rd;
  logic                  d_wr;
  logic                  ram_wr;
  logic                  mmio_wr;
  logic                  inst_wr_hit;
  logic [31:0]           mmio_rdata;
  logic [31:0]           inst_rdata_p1;
  logic [31:0]           data_rdata_p1;
  logic [15:0]           led_p1;
  logic [31:0]           timer_p1;
  logic                  unused_bits;

  // The fetch side never writes, and the low/high address bits outside the
  // word index and MMIO offset do not participate in decode.
  assign unused_bits = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr, data_sram_addr};

  assign iidx        = inst_sram_addr[DEPTH_LOG2+1:2];
  assign didx        = data_sram_addr[DEPTH_LOG2+1:2];
  assign ofs         = data_sram_addr[15:2];
  assign mmio_sel    = (data_sram_addr[31:16] == MMIO_HI);
  // Requests arriving on a reset edge are discarded entirely.
  assign d_rd        = resetn && data_sram_en && (data_sram_we == 4'b0000);
  assign d_wr        = resetn && data_sram_en && (data_sram_we != 4'b0000);
  assign ram_wr      = d_wr && !mmio_sel;
  assign mmio_wr     = d_wr && mmio_sel;
  assign inst_wr_hit = ram_wr && (didx == iidx);

`ifdef SRAM_PERF_CNT_EN
  logic [31:0] ird_cnt_p1;
  logic [31:0] drd_cnt_p1;
  logic [31:0] dwr_cnt_p1;

  // Access counters; a same-edge read of a counter sees the old value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ird_cnt_p1 <= 32'h0;
      drd_cnt_p1 <= 32'h0;
      dwr_cnt_p1 <= 32'h0;
    end else begin
      if (inst_sram_en) ird_cnt_p1 <= ird_cnt_p1 + 32'd1;
      if (d_rd)         drd_cnt_p1 <= drd_cnt_p1 + 32'd1;
      if (d_wr)         dwr_cnt_p1 <= dwr_cnt_p1 + 32'd1;
    end
  end
`endif

  // MMIO read mux, built from pre-edge register values.
  always_comb begin
    mmio_rdata = 32'h0;
    case (ofs)
      OFS_LED:   mmio_rdata = {16'h0, led_p1};
      OFS_TIMER: mmio_rdata = timer_p1;
`ifdef SRAM_PERF_CNT_EN
      OFS_IRD:   mmio_rdata = ird_cnt_p1;
      OFS_DRD:   mmio_rdata = drd_cnt_p1;
      OFS_DWR:   mmio_rdata = dwr_cnt_p1;
`endif
      default:   mmio_rdata = 32'h0;
    endcase
  end

  // RAM byte-lane writes from the data port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[didx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Stage p1: fetch read, write-first against a same-edge data store.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_rdata_p1 <= 32'h0;
    end else if (inst_sram_en) begin
      inst_rdata_p1 <= inst_wr_hit ? merge_bytes(mem[iidx], data_sram_wdata, data_sram_we)
                                   : mem[iidx];
    end
  end

  // Stage p1: data read from RAM or MMIO; stores leave the result untouched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_rdata_p1 <= 32'h0;
    end else if (d_rd) begin
      data_rdata_p1 <= mmio_sel ? mmio_rdata : mem[didx];
    end
  end

  // LED register: only the two low byte lanes exist.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_p1 <= 16'h0;
    end else if (mmio_wr && (ofs == OFS_LED)) begin
      if (data_sram_we[0]) led_p1[7:0]  <= data_sram_wdata[7:0];
      if (data_sram_we[1]) led_p1[15:8] <= data_sram_wdata[15:8];
    end
  end

  // Free-running timer; a write replaces the increment for that edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer_p1 <= 32'h0;
    end else if (mmio_wr && (ofs == OFS_TIMER)) begin
      timer_p1 <= merge_bytes(timer_p1, data_sram_wdata, data_sram_we);
    end else begin
      timer_p1 <= timer_p1 + 32'd1;
    end
  end

  assign inst_sram_rdata = inst_rdata_p1;
  assign data_sram_rdata = data_rdata_p1;
  assign led             = led_p1;

endmodule

// File: tb/tb_cpu_sram_resp.sv
// Self-checking bench for cpu_sram_resp (build with +define+SRAM_PERF_CNT_EN
// to cover the access counters).
module tb_cpu_sram_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;

  int errors = 0;
  int checks = 0;

  logic [31:0] qd[$];
  logic [31:0] qi[$];
  logic [31:0] model[int];

  cpu_sram_resp dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: drive both ports, take the edge, settle 1 time unit after it.
  task automatic cyc(input logic den, input logic [3:0] dwe, input logic [31:0] da,
                     input logic [31:0] dwd, input logic ien, input logic [31:0] ia);
    data_sram_en    = den;
    data_sram_we    = dwe;
    data_sram_addr  = da;
    data_sram_wdata = dwd;
    inst_sram_en    = ien;
    inst_sram_addr  = ia;
    @(posedge clk);
    #1;
  endtask

  function automatic void mwr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int k;
    logic [31:0] w;
    k = int'(a[15:2]);
    w = model.exists(k) ? model[k] : 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    model[k] = w;
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    int k;
    k = int'(a[15:2]);
    return model.exists(k) ? model[k] : 32'hxxxxxxxx;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
    cyc(1'b1, 4'h0, 32'h4, 32'h0, 1'b1, 32'h4);
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_drdata: got %h want %h", data_sram_rdata, 32'h0); end
    checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_irdata: got %h want %h", inst_sram_rdata, 32'h0); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
    resetn = 1'b1;
  endtask

  task automatic test_rw();
    logic [31:0] exp;
    cyc(1'b1, 4'hf, 32'h1c000100, 32'h12345678, 1'b0, 32'h0);
    mwr(32'h1c000100, 32'h12345678, 4'hf);
    qd.push_back(32'h12345678);
    cyc(1'b1, 4'h0, 32'h1c000100, 32'h0, 1'b0, 32'h0);
    exp = qd.pop_front();
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL rw_full: got %h want %h", data_sram_rdata, exp); end
    cyc(1'b1, 4'b0010, 32'h1c000100, 32'h0000ab00, 1'b0, 32'h0);
    mwr(32'h1c000100, 32'h0000ab00, 4'b0010);
    qd.push_back(32'h1234ab78);
    cyc(1'b1, 4'h0, 32'h1c000100, 32'h0, 1'b0, 32'h0);
    exp = qd.pop_front();
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL rw_byte: got %h want %h", data_sram_rdata, exp); end
    // Dual-port: independent reads on both ports in the same cycle.
    cyc(1'b1, 4'hf, 32'h0, 32'ha5a50001, 1'b0, 32'h0);
    mwr(32'h0, 32'ha5a50001, 4'hf);
    qd.push_back(mrd(32'h0));
    qi.push_back(mrd(32'h1c000100));
    cyc(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 32'h1c000100);
    exp = qd.pop_front();
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL dual_data: got %h want %h", data_sram_rdata, exp); end
    exp = qi.pop_front();
    checks++; if (inst_sram_rdata !== exp) begin errors++; $display("FAIL dual_inst: got %h want %h", inst_sram_rdata, exp); end
  endtask

  task automatic test_same_edge();
    logic [31:0] exp;
    qi.push_back(32'hdeadbeef);
    cyc(1'b1, 4'hf, 32'h100, 32'hdeadbeef, 1'b1, 32'h100);
    mwr(32'h100, 32'hdeadbeef, 4'hf);
    exp = qi.pop_front();
    checks++; if (inst_sram_rdata !== exp) begin errors++; $display("FAIL wfirst_full: got %h want %h", inst_sram_rdata, exp); end
    // Fetch-side write enables must not modify RAM.
    inst_sram_we    = 4'hf;
    inst_sram_wdata = 32'h0;
    qi.push_back(32'hdeadbeef);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h100);
    inst_sram_we = 4'h0;
    exp = qi.pop_front();
    checks++; if (inst_sram_rdata !== exp) begin errors++; $display("FAIL inst_we_read: got %h want %h", inst_sram_rdata, exp); end
    qd.push_back(mrd(32'h100));
    cyc(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 32'h0);
    exp = qd.pop_front();
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL inst_we_ignored: got %h want %h", data_sram_rdata, exp); end
    // Partial store merged into a same-edge fetch.
    cyc(1'b1, 4'hf, 32'h104, 32'h01020304, 1'b0, 32'h0);
    mwr(32'h104, 32'h01020304, 4'hf);
    mwr(32'h104, 32'h000000ee, 4'b0001);
    qi.push_back(mrd(32'h104));
    cyc(1'b1, 4'b0001, 32'h104, 32'h000000ee, 1'b1, 32'h104);
    exp = qi.pop_front();
    checks++; if (inst_sram_rdata !== exp) begin errors++; $display("FAIL wfirst_merge: got %h want %h", inst_sram_rdata, exp); end
  endtask

  task automatic test_hold();
    logic [31:0] exp;
    exp = mrd(32'h0);
    cyc(1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 32'h0);
      checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL hold_idle%0d: got %h want %h", i, data_sram_rdata, exp); end
    end
    cyc(1'b1, 4'hf, 32'h8, 32'h77777777, 1'b0, 32'h0);
    mwr(32'h8, 32'h77777777, 4'hf);
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL hold_write: got %h want %h", data_sram_rdata, exp); end
  endtask

  task automatic test_led();
    logic [31:0] exp;
    cyc(1'b1, 4'hf, 32'hbfaf0000, 32'hffff1234, 1'b0, 32'h0);
    checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_write: got %h want %h", led, 16'h1234); end
    qd.push_back(32'h00001234);
    cyc(1'b1, 4'h0, 32'hbfaf0000, 32'h0, 1'b0, 32'h0);
    exp = qd.pop_front();
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL led_read: got %h want %h", data_sram_rdata, exp); end
    cyc(1'b1, 4'b1100, 32'hbfaf0000, 32'hffffffff, 1'b0, 32'h0);
    checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_upper_we: got %h want %h", led, 16'h1234); end
    cyc(1'b1, 4'hf, 32'hbfaf0008, 32'hffffffff, 1'b0, 32'h0);
    qd.push_back(32'h0);
    cyc(1'b1, 4'h0, 32'hbfaf0008, 32'h0, 1'b0, 32'h0);
    exp = qd.pop_front();
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL unmapped: got %h want %h", data_sram_rdata, exp); end
    // The fetch port does not decode MMIO: this aliases RAM word 0.
    qi.push_back(mrd(32'h0));
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hbfaf0000);
    exp = qi.pop_front();
    checks++; if (inst_sram_rdata !== exp) begin errors++; $display("FAIL inst_no_mmio: got %h want %h", inst_sram_rdata, exp); end
    do_reset();
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL rst_led: got %h want %h", led, 16'h0); end
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL rst_drdata: got %h want %h", data_sram_rdata, 32'h0); end
    checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL rst_irdata: got %h want %h", inst_sram_rdata, 32'h0); end
    qi.push_back(32'hdeadbeef);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h100);
    exp = qi.pop_front();
    checks++; if (inst_sram_rdata !== exp) begin errors++; $display("FAIL ram_kept: got %h want %h", inst_sram_rdata, exp); end
  endtask

  task automatic test_timer();
    logic [31:0] exp;
    do_reset();
    repeat (9) cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    qd.push_back(32'd9);
    cyc(1'b1, 4'h0, 32'hbfaf0004, 32'h0, 1'b0, 32'h0);
    exp = qd.pop_front();
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL timer_count: got %h want %h", data_sram_rdata, exp); end
    cyc(1'b1, 4'hf, 32'hbfaf0004, 32'hfffffffe, 1'b0, 32'h0);
    qd.push_back(32'hfffffffe);
    qd.push_back(32'hffffffff);
    qd.push_back(32'h00000000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'h0, 32'hbfaf0004, 32'h0, 1'b0, 32'h0);
      exp = qd.pop_front();
      checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL timer_wrap%0d: got %h want %h", i, data_sram_rdata, exp); end
    end
    // Timer holds 1 now; byte 1 written, byte 0 keeps pre-increment value.
    cyc(1'b1, 4'b0010, 32'hbfaf0004, 32'h00005500, 1'b0, 32'h0);
    qd.push_back(32'h00005501);
    cyc(1'b1, 4'h0, 32'hbfaf0004, 32'h0, 1'b0, 32'h0);
    exp = qd.pop_front();
    checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL timer_bytewr: got %h want %h", data_sram_rdata, exp); end
  endtask

  task automatic test_perf();
    logic [31:0] exp;
    do_reset();
    repeat (3) cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h100);
    repeat (2) cyc(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 4'hf, 32'h10c, 32'h5a5a5a5a, 1'b0, 32'h0);
    mwr(32'h10c, 32'h5a5a5a5a, 4'hf);
`ifdef SRAM_PERF_CNT_EN
    qd.push_back(32'd3);
    qd.push_back(32'd3);
    qd.push_back(32'd1);
`else
    qd.push_back(32'd0);
    qd.push_back(32'd0);
    qd.push_back(32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'h0, 32'hbfaf0010 + 32'(4 * i), 32'h0, 1'b0, 32'h0);
      exp = qd.pop_front();
      checks++; if (data_sram_rdata !== exp) begin errors++; $display("FAIL perf_cnt%0d: got %h want %h", i, data_sram_rdata, exp); end
    end
  endtask

  initial begin
    resetn          = 1'b0;
    inst_sram_en    = 1'b0;
    inst_sram_we    = 4'h0;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    test_reset();
    test_rw();
    test_same_edge();
    test_hold();
    test_led();
    test_timer();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sram_resp.md
Name: cpu_sram_resp

Overview:
Responder for the core's inst and data SRAM ports. Serves fetch and load/store traffic from one shared word array with 1-cycle read latency and byte-enable writes. Also decodes a small MMIO window on the data port: an LED register and a free-running timer. Instantiated in the SoC/testbench next to the core top, wired directly to its inst_sram_* and data_sram_* pins.

Parameters:
DEPTH_LOG2, 14, log2 of RAM depth in 32-bit words (default 16K words, 64 KB)
MMIO_HI, 16'hbfaf, value of addr[31:16] that selects the MMIO window on the data port

Ports:
clk  in  1  system clock, all state updates on posedge
resetn  in  1  synchronous active-low reset
inst_sram_en  in  1  fetch request this cycle
inst_sram_we  in  4  byte write enables from fetch side; must be 0, ignored
inst_sram_addr  in  32  fetch byte address
inst_sram_wdata  in  32  unused
inst_sram_rdata  out  32  fetch data, valid the cycle after en
data_sram_en  in  1  load/store request this cycle
data_sram_we  in  4  byte write enables; 0 = read
data_sram_addr  in  32  load/store byte address
data_sram_wdata  in  32  store data, byte lanes aligned to we
data_sram_rdata  out  32  load data, valid the cycle after a read request
led  out  16  MMIO LED register contents

Behaviour:
- Word index = addr[DEPTH_LOG2+1:2]. addr[1:0] and unused upper bits are ignored; RAM aliases across the space.
- Read: en=1 at edge N -> rdata = word at edge N+1. rdata holds its value until the next read on that port. No handshake and no stall: every request completes in 1 cycle.
- Data write (en=1, we!=0):
  - each byte lane i with we[i]=1 takes wdata[8i+7:8i] at the posedge;
  - data_sram_rdata holds (a write does not update it).
- Inst port:
  - never writes, regardless of inst_sram_we;
  - MMIO window is not decoded on inst; those addresses read RAM.
- Same-edge inst read + data write to the same RAM word: write-first. inst_sram_rdata returns the merged word (new bytes where we[i]=1, old bytes elsewhere).
- MMIO (data port, addr[31:16]==MMIO_HI, RAM untouched):
  - offset 16'h0000 LED: RW, bits 15:0 used, upper read 0; we[1:0] honoured, we[3:2] ignored; drives led.
  - offset 16'h0004 TIMER: 32-bit, +1 every cycle, wraps 32'hffffffff -> 0; byte-enable writable.
  - Write and increment on the same edge: written bytes take wdata, unwritten bytes take the pre-increment value; timer resumes +1 next cycle.
  - Timer read returns the value before that edge's increment.
  - Unmapped offsets: read 32'h0, writes dropped.
- Reset (resetn=0 at an edge):
  - inst_sram_rdata, data_sram_rdata, led, TIMER -> 0;
  - RAM contents are not cleared;
  - a request on the same edge as reset is discarded, so rdata stays 0.
- Simultaneous inst and data reads are independent and both complete in 1 cycle (true dual-port).

Optional Feature:
SRAM_PERF_CNT_EN
- Defined: three 32-bit wrapping counters, reset 0, read-only, in the MMIO window:
  - 16'h0010 inst read count (+1 per inst_sram_en);
  - 16'h0014 data read count (data_sram_en && we==0, MMIO included);
  - 16'h0018 data write count (data_sram_en && we!=0).
  - A read of a counter returns its value before the current edge's increment. Writes to these offsets are dropped.
- Undefined: no counters are built and offsets 0x10-0x18 read 0 like any other unmapped offset.

Test Plan:
- Write 32'h12345678 to 0x1c000100 with we=4'hf; next cycle read it -> data_sram_rdata=32'h12345678 one cycle after en; then write we=4'b0010 with wdata 32'h0000ab00 and read -> 32'h1234ab78.
- Same edge: data write 32'hdeadbeef to word 0x40 and inst read of word 0x40 -> inst_sram_rdata=32'hdeadbeef next cycle; inst_sram_we=4'hf with en -> RAM unchanged.
- Read at 0x00 then idle 5 cycles with en=0 -> data_sram_rdata holds the first value; a write cycle also leaves rdata unchanged.
- Release reset, read TIMER at cycle 10 -> value 9 or 10 per the fixed post-reset offset, consistent each run; write TIMER=32'hfffffffe, read 2 cycles later -> wraps to 32'h0.
- Write LED 32'hffff1234 with we=4'hf -> led=16'h1234, readback 32'h00001234; assert resetn=0 one cycle -> led=0, both rdata=0, RAM word 0x40 still holds 32'hdeadbeef.
- With SRAM_PERF_CNT_EN: 3 inst fetches, 2 data reads, 1 store, then read 0x10/0x14/0x18 -> counts reflect those accesses (data read count includes the reads of the counters themselves); without the macro, all three offsets read 0.
